// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator: pixel-enable divider, h/v counters, syncs, strobes.
// Optional frame counter enabled by defining VGA_FRAME_CNT_EN.
module vga_timing_ctrl #(
  parameter int unsigned DIV       = 4,
  parameter int unsigned CW        = 10,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter logic        SYNC_POL  = 1'b0
) (
  input  logic          clk100,
  input  logic          rst_n,
  input  logic          en,
  output logic          pix_tick,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          line_start,
  output logic          frame_start,
  output logic [15:0]   frame_cnt
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [CW-1:0]    H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0]    V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0]    H_VIS    = CW'(H_VISIBLE);
  localparam logic [CW-1:0]    V_VIS    = CW'(V_VISIBLE);
  localparam logic [CW-1:0]    HS_BEG   = CW'(H_VISIBLE + H_FP);
  localparam logic [CW-1:0]    HS_END   = CW'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0]    VS_BEG   = CW'(V_VISIBLE + V_FP);
  localparam logic [CW-1:0]    VS_END   = CW'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam logic             SYNC_ACT  = SYNC_POL;
  localparam logic             SYNC_IDLE = ~SYNC_POL;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [CW-1:0]    hcount_q, hcount_d;
  logic [CW-1:0]    vcount_q, vcount_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_on_q, video_on_d;
  logic             pix_tick_q, pix_tick_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;

  logic             tick_c;
  logic             h_wrap_c;
  logic [CW-1:0]    h_next_c;
  logic [CW-1:0]    v_next_c;

  // Divider and raster advance; decoded outputs use the post-advance position
  always_comb begin
    tick_c        = en && (div_cnt_q == DIV_LAST);
    div_cnt_d     = div_cnt_q;
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    video_on_d    = video_on_q;
    pix_tick_d    = 1'b0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    h_wrap_c = (hcount_q == H_LAST);
    h_next_c = h_wrap_c ? '0 : hcount_q + CW'(1);
    if (h_wrap_c) begin
      v_next_c = (vcount_q == V_LAST) ? '0 : vcount_q + CW'(1);
    end else begin
      v_next_c = vcount_q;
    end

    if (en) begin
      div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
    end

    if (tick_c) begin
      pix_tick_d    = 1'b1;
      hcount_d      = h_next_c;
      vcount_d      = v_next_c;
      hsync_d       = (h_next_c >= HS_BEG && h_next_c <= HS_END) ? SYNC_ACT : SYNC_IDLE;
      vsync_d       = (v_next_c >= VS_BEG && v_next_c <= VS_END) ? SYNC_ACT : SYNC_IDLE;
      video_on_d    = (h_next_c < H_VIS) && (v_next_c < V_VIS);
      line_start_d  = (h_next_c == '0);
      frame_start_d = (h_next_c == '0) && (v_next_c == '0);
    end
  end

  // Reset parks the raster on the last pixel so the first tick lands on (0,0)
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q     <= '0;
      hcount_q      <= H_LAST;
      vcount_q      <= V_LAST;
      hsync_q       <= SYNC_IDLE;
      vsync_q       <= SYNC_IDLE;
      video_on_q    <= 1'b0;
      pix_tick_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      pix_tick_q    <= pix_tick_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Counts frame_start events; wraps naturally at 16 bits
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_start_d) begin
      frame_cnt_d = frame_cnt_q + 16'(1);
    end
  end

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = '0;
`endif

  assign pix_tick    = pix_tick_q;
  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule
